// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: register offsets, status bit
// positions and receive FSM state encoding.
package uart_rx_pkg;

  localparam logic [7:0] REG_RXDATA = 8'h10;
  localparam logic [7:0] REG_DIV    = 8'h14;
  localparam logic [7:0] REG_STATUS = 8'h18;

  localparam int unsigned STAT_NONEMPTY  = 0;
  localparam int unsigned STAT_OVERRUN   = 1;
  localparam int unsigned STAT_FRAME_ERR = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push on full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: oversampling deframer feeding a receive
// FIFO that the CPU pops through the data register.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] DEFAULT_DIV = 32'd1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        r_sync1;
  logic        r_rx_s;
  logic        r_rx_prev;
  rx_state_e   r_state;
  rx_state_e   w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic [2:0]  r_bitn;
  logic [2:0]  w_bitn_nxt;
  logic [7:0]  r_shreg;
  logic [7:0]  w_shreg_nxt;
  logic [31:0] r_div;
  logic        r_overrun;
  logic        r_frame_err;
  logic [31:0] r_rdata;
  logic        r_irq;

  logic          w_tick;
  logic          w_div_wr;
  logic          w_stat_wr;
  logic          w_pop_req;
  logic          w_stop_ok;
  logic          w_stop_bad;
  logic          w_fifo_push;
  logic          w_overrun_set;
  logic [7:0]    w_fifo_dout;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_data;
  logic          w_unused_addr;

  assign w_unused_addr = ^addr[31:8];
  assign w_tick        = (r_cnt == 32'd0);
  assign w_div_wr      = wen && (addr[7:0] == REG_DIV);
  assign w_stat_wr     = wen && (addr[7:0] == REG_STATUS);
  assign w_pop_req     = ren && (addr[7:0] == REG_RXDATA) && !w_fifo_empty;
  // A good stop bit on a full FIFO still lands if the CPU pops in the same cycle.
  assign w_fifo_push   = w_stop_ok && (!w_fifo_full || w_pop_req);
  assign w_overrun_set = w_stop_ok && w_fifo_full && !w_pop_req;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (w_fifo_push),
    .pop   (w_pop_req),
    .din   (r_shreg),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= 32'd0;
      r_bitn    <= 3'd0;
      r_shreg   <= 8'd0;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bitn    <= w_bitn_nxt;
      r_shreg   <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_tick ? r_div : (r_cnt - 32'd1);
    w_bitn_nxt  = r_bitn;
    w_shreg_nxt = r_shreg;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = r_div >> 1;
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (!r_rx_s) begin
            w_state_nxt = RX_DATA;
            w_bitn_nxt  = 3'd0;
          end else begin
            w_state_nxt = RX_IDLE;
          end
        end else begin
          w_state_nxt = RX_START;
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          w_shreg_nxt = {r_rx_s, r_shreg[7:1]};
          w_bitn_nxt  = r_bitn + 3'd1;
          w_state_nxt = (r_bitn == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          w_state_nxt = RX_DATA;
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          w_stop_ok   = r_rx_s;
          w_stop_bad  = !r_rx_s;
          w_state_nxt = RX_IDLE;
        end else begin
          w_state_nxt = RX_STOP;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
    // Reprogramming the bit rate abandons whatever frame was being sampled.
    if (w_div_wr) begin
      w_state_nxt = RX_IDLE;
      w_stop_ok   = 1'b0;
      w_stop_bad  = 1'b0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_div       <= DEFAULT_DIV;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_div_wr) r_div <= wdata;
      if (w_overrun_set)                 r_overrun <= 1'b1;
      else if (w_stat_wr && wdata[1])    r_overrun <= 1'b0;
      if (w_stop_bad)                    r_frame_err <= 1'b1;
      else if (w_stat_wr && wdata[2])    r_frame_err <= 1'b0;
    end
  end

  assign w_status = {16'd0, 8'(w_fifo_count), 5'd0, r_frame_err, r_overrun, !w_fifo_empty};

  always_comb begin
    w_rd_data = 32'd0;
    case (addr[7:0])
      REG_RXDATA: w_rd_data = w_fifo_empty ? 32'd0 : {24'd0, w_fifo_dout};
      REG_DIV:    w_rd_data = r_div;
      REG_STATUS: w_rd_data = w_status;
      default:    w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_rdata <= 32'd0;
      r_irq   <= 1'b0;
    end else begin
      if (ren) r_rdata <= w_rd_data;
      r_irq <= (w_fifo_count != '0);
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a queue-based model of the receive FIFO and sticky flags.
module tb_uart_rx;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic        wen;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rx;
  logic        irq;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  q[$];
  bit          m_ovr;
  bit          m_ferr;
  logic [31:0] rd;
  logic [7:0]  b;
  bit          ok;
  int          div;

  uart_rx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(32'd1)) dut (
    .CLK(CLK), .reset(reset), .wen(wen), .ren(ren), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rx(rx), .irq(irq)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK); wen = 1'b1; addr = a; wdata = d;
    @(negedge CLK); wen = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLK); ren = 1'b1; addr = a;
    @(negedge CLK); ren = 1'b0; addr = 32'd0; d = rdata;
  endtask

  // One 8N1 frame, each bit held d+1 clocks, followed by idle-high bits.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int d, input int idle_bits);
    logic v;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop_ok;
      else             v = data[i-1];
      @(negedge CLK); rx = v;
      repeat (d) @(negedge CLK);
    end
    @(negedge CLK); rx = 1'b1;
    repeat (idle_bits * (d + 1) - 1) @(negedge CLK);
  endtask

  function automatic void model_frame(input logic [7:0] data, input bit stop_ok);
    if (!stop_ok)             m_ferr = 1'b1;
    else if (q.size() < DEPTH) q.push_back(data);
    else                      m_ovr = 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [7:0] c;
    c = 8'(q.size());
    return {16'd0, c, 5'd0, m_ferr, m_ovr, (q.size() != 0)};
  endfunction

  function automatic logic [31:0] model_pop();
    if (q.size() == 0) return 32'd0;
    return {24'd0, q.pop_front()};
  endfunction

  initial begin
    reset = 1'b0; wen = 1'b0; ren = 1'b0; rx = 1'b1; addr = 32'd0; wdata = 32'd0;
    m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    check_eq("reset_rdata", rdata, 32'd0);
    check_eq("reset_irq", {31'd0, irq}, 32'd0);
    bus_read(32'h7000_0014, rd); check_eq("reset_div", rd, 32'd1);
    bus_read(32'h7000_0018, rd); check_eq("reset_status", rd, 32'd0);

    // Single frame at 4 clocks per bit.
    bus_write(32'h7000_0014, 32'd3);
    send_frame(8'hA5, 1'b1, 3, 2);
    check_eq("a5_irq", {31'd0, irq}, 32'd1);
    bus_read(32'h7000_0018, rd); check_eq("a5_status", rd, 32'h0000_0101);
    bus_read(32'h7000_0010, rd); check_eq("a5_data", rd, 32'h0000_00A5);
    bus_read(32'h7000_0018, rd); check_eq("a5_status_after", rd, 32'd0);
    check_eq("a5_irq_low", {31'd0, irq}, 32'd0);

    // Overrun with a 4-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 3, 2);
    bus_read(32'h7000_0018, rd); check_eq("ovr_status", rd, 32'h0000_0403);
    for (int i = 1; i <= 4; i++) begin
      bus_read(32'h7000_0010, rd); check_eq("ovr_data", rd, 32'(i));
    end
    bus_read(32'h7000_0010, rd); check_eq("ovr_empty_read", rd, 32'd0);
    bus_write(32'h7000_0018, 32'h2);
    bus_read(32'h7000_0018, rd); check_eq("ovr_cleared", rd, 32'd0);

    // Framing error is sticky across a later good frame.
    send_frame(8'h3C, 1'b0, 3, 2);
    bus_read(32'h7000_0018, rd); check_eq("ferr_status", rd, 32'h0000_0004);
    send_frame(8'h7E, 1'b1, 3, 2);
    bus_read(32'h7000_0018, rd); check_eq("ferr_then_good", rd, 32'h0000_0105);
    bus_read(32'h7000_0010, rd); check_eq("ferr_good_data", rd, 32'h0000_007E);
    bus_write(32'h7000_0018, 32'h4);
    bus_read(32'h7000_0018, rd); check_eq("ferr_cleared", rd, 32'd0);

    // One-clock glitch at 10 clocks per bit must not start a frame.
    bus_write(32'h7000_0014, 32'd9);
    @(negedge CLK); rx = 1'b0;
    @(negedge CLK); rx = 1'b1;
    repeat (40) @(negedge CLK);
    bus_read(32'h7000_0018, rd); check_eq("glitch_status", rd, 32'd0);
    check_eq("glitch_irq", {31'd0, irq}, 32'd0);

    // Pop in the very cycle the stop-bit push lands on a full FIFO.
    bus_write(32'h7000_0014, 32'd3);
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 3, 2);
    fork
      send_frame(8'h15, 1'b1, 3, 2);
      begin
        repeat (41) @(negedge CLK);
        ren = 1'b1; addr = 32'h7000_0010;
        @(negedge CLK); ren = 1'b0; addr = 32'd0; rd = rdata;
      end
    join
    check_eq("pushpop_data", rd, 32'h0000_0011);
    bus_read(32'h7000_0018, rd); check_eq("pushpop_status", rd, 32'h0000_0401);
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h7000_0010, rd); check_eq("pushpop_drain", rd, 32'h12 + 32'(i));
    end

    // Reset in the middle of a data bit while a pop is pending.
    send_frame(8'h5A, 1'b1, 3, 2);
    @(negedge CLK); rx = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); rx = (i == 1);
      repeat (3) @(negedge CLK);
    end
    @(negedge CLK); rx = 1'b1; reset = 1'b0; ren = 1'b1; addr = 32'h7000_0010;
    @(negedge CLK); reset = 1'b1; ren = 1'b0; addr = 32'd0;
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    bus_read(32'h7000_0018, rd); check_eq("rst_status", rd, 32'd0);
    bus_read(32'h7000_0014, rd); check_eq("rst_div", rd, 32'd1);
    repeat (10) @(negedge CLK);
    send_frame(8'hC3, 1'b1, 1, 2);
    bus_read(32'h7000_0010, rd); check_eq("rst_c3", rd, 32'h0000_00C3);

    // Randomized frames against the model.
    q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
    for (int n = 0; n < 16; n++) begin
      div = $urandom_range(1, 7);
      bus_write(32'h7000_0014, 32'(div));
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok, div, 2);
      model_frame(b, ok);
      check_eq("rnd_irq", {31'd0, irq}, {31'd0, (q.size() != 0)});
      if ($urandom_range(0, 1) == 1) begin
        bus_read(32'h7000_0010, rd); check_eq("rnd_data", rd, model_pop());
      end
      if ($urandom_range(0, 2) == 0) begin
        bus_read(32'h7000_0018, rd); check_eq("rnd_status", rd, exp_status());
      end
    end
    bus_read(32'h7000_0018, rd); check_eq("rnd_final_status", rd, exp_status());
    while (q.size() != 0) begin
      bus_read(32'h7000_0010, rd); check_eq("rnd_drain", rd, model_pop());
    end
    bus_write(32'h7000_0018, 32'h6);
    m_ovr = 1'b0; m_ferr = 1'b0;
    bus_read(32'h7000_0018, rd); check_eq("rnd_clear", rd, exp_status());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
